// File: rtl/clarvi_arb_pkg.sv
// Shared types and constants for the Clarvi shared-memory arbiter.
package clarvi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD
  } arb_state_e;

  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;
  localparam int          GRANT_W    = 3;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin picker: first set bit of req searching upward from (ptr+1) mod N with wrap.
module rr_priority_pick #(
  parameter int N     = 6,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    // Scan farthest-first so the requester nearest after ptr is the last (winning) write.
    for (int i = N; i >= 1; i--) begin
      cand = IDX_W'((int'(ptr) + i) % N);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/clarvi_mem_arbiter.sv
// Round-robin Avalon-MM arbiter: serialises single-word transactions from Clarvi cores onto one slave.
module clarvi_mem_arbiter
  import clarvi_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 6,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]     m_address,
  input  logic [NUM_MASTERS-1:0]                 m_read,
  input  logic [NUM_MASTERS-1:0]                 m_write,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]     m_writedata,
  input  logic [NUM_MASTERS-1:0][DATA_W/8-1:0]   m_byteenable,
  output logic [NUM_MASTERS-1:0]                 m_waitrequest,
  output logic [DATA_W-1:0]                      m_readdata,
  output logic [ADDR_W-1:0]                      s_address,
  output logic                                   s_read,
  output logic                                   s_write,
  output logic [DATA_W-1:0]                      s_writedata,
  output logic [DATA_W/8-1:0]                    s_byteenable,
  input  logic                                   s_waitrequest,
  input  logic [DATA_W-1:0]                      s_readdata,
  input  logic                                   s_readdatavalid,
  output logic                                   timeout_err,
  output logic [GRANT_W-1:0]                     grant_id
);

  localparam int               CNT_W       = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  arb_state_e         state, state_n;
  logic [GRANT_W-1:0] ptr, ptr_n;
  logic [GRANT_W-1:0] grant, grant_n;
  logic [CNT_W-1:0]   cnt, cnt_n;

  logic [NUM_MASTERS-1:0] req;
  logic                   pick_valid;
  logic [GRANT_W-1:0]     pick_idx;
  logic                   timed_out;
  logic                   complete;
  logic                   abort;

  assign req      = m_read | m_write;
  assign grant_id = grant;

  rr_priority_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (GRANT_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that skips an assignment would infer a latch.
    state_n       = state;
    ptr_n         = ptr;
    grant_n       = grant;
    cnt_n         = cnt;
    m_waitrequest = '1;
    m_readdata    = '0;
    timeout_err   = 1'b0;
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_address     = m_address[grant];
    s_writedata   = m_writedata[grant];
    s_byteenable  = m_byteenable[grant];
    timed_out     = (cnt == TIMEOUT_CNT);
    complete      = 1'b0;
    abort         = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_n = pick_idx;
          cnt_n   = '0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        s_read  = m_read[grant];
        s_write = m_write[grant] & ~m_read[grant];
        cnt_n   = cnt + 1'b1;
        if (s_write && !s_waitrequest) begin
          complete = 1'b1;
        end else if (timed_out) begin
          abort = 1'b1;
        end else if (s_read && !s_waitrequest) begin
          state_n = WAIT_RD;
        end
      end
      WAIT_RD: begin
        cnt_n = cnt + 1'b1;
        if (s_readdatavalid) begin
          complete   = 1'b1;
          m_readdata = s_readdata;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (complete || abort) begin
      m_waitrequest[grant] = 1'b0;
      ptr_n                = grant;
      state_n              = IDLE;
    end
    if (abort) begin
      m_readdata  = DATA_W'(ABORT_DATA);
      timeout_err = 1'b1;
    end

    // Reset kills any in-flight transaction immediately: no completion reaches the master.
    if (reset) begin
      m_waitrequest = '1;
      m_readdata    = '0;
      timeout_err   = 1'b0;
      s_read        = 1'b0;
      s_write       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    if (reset) begin
      state <= IDLE;
      ptr   <= GRANT_W'(NUM_MASTERS - 1);
      grant <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      grant <= grant_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_clarvi_mem_arbiter.sv
// Self-checking bench for clarvi_mem_arbiter: transaction-level round-robin model plus a simple slave.
module tb_clarvi_mem_arbiter;

  localparam int NM = 6;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 20;
  localparam logic [DW-1:0] ABORT = 32'hDEADBEEF;

  logic                   clk;
  logic                   reset;
  logic [NM-1:0][AW-1:0]  m_address;
  logic [NM-1:0]          m_read;
  logic [NM-1:0]          m_write;
  logic [NM-1:0][DW-1:0]  m_writedata;
  logic [NM-1:0][BW-1:0]  m_byteenable;
  logic [NM-1:0]          m_waitrequest;
  logic [DW-1:0]          m_readdata;
  logic [AW-1:0]          s_address;
  logic                   s_read;
  logic                   s_write;
  logic [DW-1:0]          s_writedata;
  logic [BW-1:0]          s_byteenable;
  logic                   s_waitrequest;
  logic [DW-1:0]          s_readdata;
  logic                   s_readdatavalid;
  logic                   timeout_err;
  logic [2:0]             grant_id;

  clarvi_mem_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT     (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_byteenable    (m_byteenable),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .s_address       (s_address),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_byteenable    (s_byteenable),
    .s_waitrequest   (s_waitrequest),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .timeout_err     (timeout_err),
    .grant_id        (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Master-side transaction state
  bit [NM-1:0]   pend, op_rd, op_wr;
  logic [AW-1:0] addr  [NM];
  logic [DW-1:0] wdata [NM];
  logic [BW-1:0] be    [NM];

  // Model and slave state
  int          last_served, exp_next;
  bit          rand_mode, cont_mode, never_valid;
  int          wait_cfg, lat_cfg;
  int          stall_left, rd_left;
  bit          rd_out;
  logic [AW-1:0] rd_addr;
  int          ev_m[$];
  int          ev_c[$];
  int          n_swrite, n_terr;
  int          checks, failures;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] data_tag(input logic [AW-1:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  // Next master served: first pending one after the last served, wrapping.
  function automatic int rr_next(input bit [NM-1:0] p, input int last);
    for (int k = 1; k <= NM; k++) begin
      if (p[(last + k) % NM]) return (last + k) % NM;
    end
    return -1;
  endfunction

  task automatic new_txn(input int j);
    int r;
    r        = int'($urandom_range(2));
    pend[j]  = 1'b1;
    op_rd[j] = (r != 1);
    op_wr[j] = (r != 0);
    addr[j]  = AW'($urandom);
    wdata[j] = $urandom;
    be[j]    = BW'($urandom_range(15));
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    pend            = '0;
    op_rd           = '0;
    op_wr           = '0;
    m_read          = '0;
    m_write         = '0;
    m_address       = '0;
    m_writedata     = '0;
    m_byteenable    = '0;
    s_waitrequest   = 1'b0;
    s_readdatavalid = 1'b0;
    s_readdata      = '0;
    rd_out          = 1'b0;
    rd_left         = 0;
    stall_left      = 0;
    last_served     = NM - 1;
    n_swrite        = 0;
    n_terr          = 0;
    ev_m.delete();
    ev_c.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One bounded run: drives masters and slave each cycle until want_ev completions or max_cyc cycles.
  task automatic run(input int max_cyc, input int want_ev);
    int cyc;
    cyc      = 0;
    exp_next = rr_next(pend, last_served);
    while (cyc < max_cyc && ev_m.size() < want_ev) begin
      bit spur, accept;
      int done_i, n_low;
      for (int i = 0; i < NM; i++) begin
        m_read[i]       = pend[i] & op_rd[i];
        m_write[i]      = pend[i] & op_wr[i];
        m_address[i]    = addr[i];
        m_writedata[i]  = wdata[i];
        m_byteenable[i] = be[i];
      end
      spur            = rand_mode && !rd_out && ($urandom_range(3) == 0);
      s_waitrequest   = (stall_left != 0);
      s_readdatavalid = (rd_out && rd_left == 0 && !never_valid) || spur;
      s_readdata      = spur ? (32'hBAD0_0000 | $urandom_range(255)) : data_tag(rd_addr);
      #2;

      if (s_write) n_swrite++;
      if (timeout_err) n_terr++;

      accept = (s_read || s_write) && !s_waitrequest;
      if (accept && exp_next >= 0) begin
        check("s_address", s_address, addr[exp_next]);
        check("s_read_prio", s_read, op_rd[exp_next]);
        if (s_write) begin
          check("s_writedata", s_writedata, wdata[exp_next]);
          check("s_byteenable", s_byteenable, be[exp_next]);
        end
      end

      done_i = -1;
      n_low  = 0;
      for (int i = 0; i < NM; i++) begin
        if (!m_waitrequest[i]) begin
          n_low++;
          done_i = i;
        end
      end
      if (n_low > 1) check("single_done", n_low, 1);

      // Slave bookkeeping
      if (rd_out && rd_left > 0) rd_left--;
      if (s_read || s_write) begin
        if (stall_left > 0) stall_left--;
        else begin
          if (s_read) begin
            rd_out  = 1'b1;
            rd_addr = s_address;
            rd_left = (rand_mode ? int'($urandom_range(3, 1)) : lat_cfg) - 1;
          end
          stall_left = rand_mode ? int'($urandom_range(3)) : wait_cfg;
        end
      end

      if (done_i >= 0) begin
        check("winner", done_i, exp_next);
        check("grant_id", grant_id, exp_next);
        if (op_rd[done_i])
          check("readdata", m_readdata, never_valid ? ABORT : data_tag(addr[done_i]));
        else
          check("wr_done_slave_ready", s_waitrequest, 1'b0);
        check("timeout_err", timeout_err, never_valid && op_rd[done_i]);
        ev_m.push_back(done_i);
        ev_c.push_back(cyc);
        last_served  = done_i;
        pend[done_i] = 1'b0;
        rd_out       = 1'b0;
        stall_left   = rand_mode ? int'($urandom_range(3)) : wait_cfg;
        if (cont_mode) begin
          addr[done_i] = addr[done_i] + 16'd1;
          pend[done_i] = 1'b1;
        end
        if (rand_mode) begin
          for (int j = 0; j < NM; j++)
            if (!pend[j] && $urandom_range(1) == 1) new_txn(j);
          if (pend == '0) new_txn(int'($urandom_range(NM - 1)));
        end
        exp_next = rr_next(pend, last_served);
      end

      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rand_mode   = 1'b0;
    cont_mode   = 1'b0;
    never_valid = 1'b0;
    wait_cfg    = 0;
    lat_cfg     = 1;

    // Reset state
    do_reset();
    #2;
    check("rst_waitrequest", m_waitrequest, {NM{1'b1}});
    check("rst_s_read", s_read, 1'b0);
    check("rst_s_write", s_write, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_grant_id", grant_id, 3'd0);
    check("rst_readdata", m_readdata, 32'd0);

    // Masters 0 and 3 write together, zero-wait slave
    do_reset();
    pend[0] = 1'b1; op_wr[0] = 1'b1; addr[0] = 16'h0010; wdata[0] = 32'h1111_0000; be[0] = 4'hF;
    pend[3] = 1'b1; op_wr[3] = 1'b1; addr[3] = 16'h0033; wdata[3] = 32'h3333_3333; be[3] = 4'h3;
    run(20, 2);
    check("wr2_count", ev_m.size(), 2);
    if (ev_m.size() == 2) begin
      check("wr2_first_master", ev_m[0], 0);
      check("wr2_first_cycle", ev_c[0], 1);
      check("wr2_second_master", ev_m[1], 3);
      check("wr2_second_cycle", ev_c[1], 3);
    end

    // All six masters read continuously, slave returns data two cycles after accept
    do_reset();
    cont_mode = 1'b1;
    lat_cfg   = 2;
    for (int i = 0; i < NM; i++) begin
      pend[i]  = 1'b1;
      op_rd[i] = 1'b1;
      addr[i]  = AW'(16'h0100 * i);
    end
    run(80, 7);
    cont_mode = 1'b0;
    check("rot_count", ev_m.size(), 7);
    if (ev_m.size() == 7) begin
      for (int k = 0; k < 7; k++) check("rot_order", ev_m[k], k % NM);
      check("rot_first_cycle", ev_c[0], 3);
    end

    // Slave stalls a write from master 2 for 10 cycles
    do_reset();
    wait_cfg   = 10;
    stall_left = 10;
    lat_cfg    = 1;
    pend[2] = 1'b1; op_wr[2] = 1'b1; addr[2] = 16'h0222; wdata[2] = 32'hCAFE_0002; be[2] = 4'hC;
    run(30, 1);
    wait_cfg = 0;
    check("stall_count", ev_m.size(), 1);
    if (ev_m.size() == 1) check("stall_done_cycle", ev_c[0], 11);
    check("stall_s_write_cycles", n_swrite, 11);

    // Slave never returns read data: watchdog abort, then next master
    do_reset();
    never_valid = 1'b1;
    pend[1] = 1'b1; op_rd[1] = 1'b1; addr[1] = 16'h0111;
    pend[2] = 1'b1; op_rd[2] = 1'b1; addr[2] = 16'h0222;
    run(80, 2);
    check("to_count", ev_m.size(), 2);
    if (ev_m.size() == 2) begin
      check("to_first_master", ev_m[0], 1);
      check("to_first_cycle", ev_c[0], TO + 1);
      check("to_second_master", ev_m[1], 2);
      check("to_second_cycle", ev_c[1], 2 * TO + 3);
    end
    check("to_pulse_cycles", n_terr, 2);

    // Reset during WAIT_RD of master 4, then master 4 alone is served normally
    do_reset();
    pend[4] = 1'b1; op_rd[4] = 1'b1; addr[4] = 16'h0444;
    run(3, 1);
    check("rstmid_no_done", ev_m.size(), 0);
    reset           = 1'b1;
    s_readdatavalid = 1'b1;
    s_readdata      = 32'h1234_5678;
    #2;
    check("rstmid_waitrequest", m_waitrequest, {NM{1'b1}});
    check("rstmid_timeout_err", timeout_err, 1'b0);
    @(posedge clk);
    #1;
    reset           = 1'b0;
    s_readdatavalid = 1'b0;
    #2;
    check("rstmid_idle_waitrequest", m_waitrequest, {NM{1'b1}});
    check("rstmid_idle_s_read", s_read, 1'b0);
    check("rstmid_idle_grant_id", grant_id, 3'd0);
    never_valid = 1'b0;
    rd_out      = 1'b0;
    stall_left  = 0;
    last_served = NM - 1;
    ev_m.delete();
    ev_c.delete();
    run(10, 1);
    check("rstmid_after_count", ev_m.size(), 1);
    if (ev_m.size() == 1) begin
      check("rstmid_after_master", ev_m[0], 4);
      check("rstmid_after_cycle", ev_c[0], 2);
    end

    // Read and write asserted together: completes as a read
    do_reset();
    wait_cfg   = 1;
    stall_left = 1;
    lat_cfg    = 2;
    pend[5] = 1'b1; op_rd[5] = 1'b1; op_wr[5] = 1'b1; addr[5] = 16'h0555; wdata[5] = 32'h5555_5555; be[5] = 4'hF;
    run(20, 1);
    wait_cfg = 0;
    check("rw_count", ev_m.size(), 1);
    check("rw_no_s_write", n_swrite, 0);

    // Randomized traffic against the round-robin model
    do_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < NM; i++) new_txn(i);
    run(3000, 80);
    rand_mode = 1'b0;
    check("rand_count", ev_m.size(), 80);
    check("rand_no_timeout", n_terr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
